// File: rtl/gravity_pkg.sv
// Shared types and helpers for the gravity-drop LED animator.
// State encoding, mode constants and a one-hot decode helper.
package gravity_pkg;

    typedef enum logic [1:0] {
        FALL = 2'd0,
        HOLD = 2'd1,
        RISE = 2'd2
    } state_t;

    localparam logic MODE_REPEAT = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    // Decode up to 64 positions; callers truncate to their LED count.
    function automatic logic [63:0] onehot64(input logic [5:0] idx);
        onehot64 = 64'd1 << idx;
    endfunction

endpackage

// File: rtl/gravity_tick_gen.sv
// Enable-gated modulo-TICK_DIV divider producing a one-cycle tick at the
// terminal count; the count freezes while en is low.
module gravity_tick_gen #(
    parameter int TICK_DIV = 381
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: hold when disabled, wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = cnt_q;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_gravity_animator.sv
// Gravity-drop LED animator: position = N_LEDS * t^2 on a falling/holding/rising
// time base. Define LED_TRAIL_EN to also light the previously displayed LED.
module led_gravity_animator
    import gravity_pkg::*;
#(
    parameter int N_LEDS     = 16,
    parameter int T_BITS     = 17,
    parameter int TICK_DIV   = 381,
    parameter int HOLD_TICKS = 8192
) (
    input  logic                        CLK100MHZ,
    input  logic                        CPU_RESETN,
    input  logic                        en,
    input  logic                        mode,
    input  logic                        flip,
    output logic [N_LEDS-1:0]           LED,
    output logic [$clog2(N_LEDS)-1:0]   pos,
    output logic                        at_bottom
);

    localparam int POS_W  = $clog2(N_LEDS);
    localparam int SQ_W   = 2 * T_BITS;
    localparam int PROD_W = SQ_W + POS_W;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [T_BITS-1:0] T_MAX     = {T_BITS{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(N_LEDS - 1);

    logic tick_s;

    state_t              state_q, state_d;
    logic [T_BITS-1:0]   t_q, t_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                mode_q, mode_d;
    logic                first_q, first_d;
    logic                at_bottom_q, at_bottom_d;

    logic [SQ_W-1:0]     t_sq_q, t_sq_d;
    logic [PROD_W-1:0]   prod_s;
    logic [POS_W-1:0]    p_s;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [N_LEDS-1:0]   led_q, led_d;

    gravity_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .en    (en),
        .tick  (tick_s)
    );

    // FSM and counter registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= FALL;
            t_q         <= '0;
            hold_cnt_q  <= '0;
            mode_q      <= MODE_REPEAT;
            first_q     <= 1'b1;
            at_bottom_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
            at_bottom_q <= at_bottom_d;
        end
    end

    // Next state; mode is only captured on the first clock and at cycle start.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        hold_cnt_d = hold_cnt_q;
        mode_d     = first_q ? mode : mode_q;
        first_d    = 1'b0;
        if (tick_s) begin
            case (state_q)
                FALL: begin
                    if (t_q == T_MAX) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        t_d = t_q + T_BITS'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (mode_q == MODE_REPEAT) begin
                            t_d     = '0;
                            mode_d  = mode;
                            state_d = FALL;
                        end else begin
                            state_d = RISE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                RISE: begin
                    if (t_q == '0) begin
                        state_d = FALL;
                        mode_d  = mode;
                    end else begin
                        t_d = t_q - T_BITS'(1);
                    end
                end
                default: begin
                    state_d    = FALL;
                    t_d        = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Strike pulse coincides with the state register first holding HOLD.
    always_comb begin
        at_bottom_d = tick_s && (state_q == FALL) && (t_q == T_MAX);
    end

    // Squaring and scaling; p never exceeds N_LEDS-1 because t^2 < 2^SQ_W.
    always_comb begin
        t_sq_d = SQ_W'(t_q) * SQ_W'(t_q);
        prod_s = PROD_W'(t_sq_q) * PROD_W'(N_LEDS);
        p_s    = POS_W'(prod_s >> SQ_W);
        pos_d  = flip ? (POS_TOP - p_s) : p_s;
    end

`ifdef LED_TRAIL_EN
    logic [POS_W-1:0] prev_pos_q, prev_pos_d;

    // Remember the position shown before the most recent move.
    always_comb begin
        prev_pos_d = (pos_d != pos_q) ? pos_q : prev_pos_q;
        led_d      = N_LEDS'(onehot64(6'(pos_q))) | N_LEDS'(onehot64(6'(prev_pos_q)));
    end

    // Trail position register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            prev_pos_q <= '0;
        end else begin
            prev_pos_q <= prev_pos_d;
        end
    end
`else
    // Strict one-hot display.
    always_comb begin
        led_d = N_LEDS'(onehot64(6'(pos_q)));
    end
`endif

    // Display pipeline: t -> t^2 -> pos -> LED.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            t_sq_q <= '0;
            pos_q  <= '0;
            led_q  <= '0;
        end else begin
            t_sq_q <= t_sq_d;
            pos_q  <= pos_d;
            led_q  <= led_d;
        end
    end

    assign LED       = led_q;
    assign pos       = pos_q;
    assign at_bottom = at_bottom_q;

endmodule
